// File: rtl/oldland_dbus_bridge.sv
// oldland_dbus_bridge: registers memory-stage data accesses onto the system bus with a timeout watchdog
module oldland_dbus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_access,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic [31:0] fault_addr,
  output logic        bus_access,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_bytesel,
  output logic        bus_wr_en,
  output logic [31:0] bus_wr_val,
  input  logic [31:0] bus_data,
  input  logic        bus_ack,
  input  logic        bus_error
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [31:0] data_q;
  logic err;
  logic timeout;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    next = state == IDLE ? (d_access ? BUSY : IDLE) :
           state == BUSY ? ((bus_error || bus_ack || timeout) ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr <= '0;
      bus_bytesel <= '0;
      bus_wr_en <= 1'b0;
      bus_wr_val <= '0;
      cnt <= '0;
      data_q <= '0;
      err <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (state == IDLE && d_access) begin
        bus_addr <= d_addr;
        bus_bytesel <= d_bytesel;
        bus_wr_en <= d_wr_en;
        bus_wr_val <= d_wr_val;
        cnt <= '0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        // a slave error beats a simultaneous ack; a silent slave becomes an error at the watchdog limit
        if (bus_error || (!bus_ack && timeout)) begin
          err <= 1'b1;
          fault_addr <= bus_addr;
        end else if (bus_ack) begin
          data_q <= bus_data;
          err <= 1'b0;
        end
      end
    end
  end
  assign bus_access = state == BUSY;
  assign d_ack = state == RESP;
  assign d_error = d_ack && err;
  assign d_data = (d_ack && !err && !bus_wr_en) ? data_q : '0;
endmodule
